// File: rtl/edge_detect_pipe.sv
// ============================================================================
// Module      : edge_detect_pipe
// Description : Two-stage 3x3 window edge classifier with valid/ready
//               handshaking and saturating per-frame edge statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_detect_pipe #(
   parameter int DATA_WIDTH        = 8,
   parameter int DEFAULT_THRESHOLD = 80,
   parameter int COUNT_WIDTH       = 20
) (
   input  logic                   clk,
   input  logic                   rst,

   input  logic                   input_valid,
   output logic                   input_ready,
   input  logic [DATA_WIDTH-1:0]  input_pixel_1,
   input  logic [DATA_WIDTH-1:0]  input_pixel_2,
   input  logic [DATA_WIDTH-1:0]  input_pixel_3,
   input  logic [DATA_WIDTH-1:0]  input_pixel_4,
   input  logic [DATA_WIDTH-1:0]  input_pixel_6,
   input  logic [DATA_WIDTH-1:0]  input_pixel_7,
   input  logic [DATA_WIDTH-1:0]  input_pixel_8,
   input  logic [DATA_WIDTH-1:0]  input_pixel_9,

   input  logic                   threshold_load,
   input  logic [DATA_WIDTH-1:0]  threshold_in,
   input  logic                   frame_end,

   output logic                   output_valid,
   input  logic                   output_ready,
   output logic [1:0]             ED_out,
   output logic [DATA_WIDTH-1:0]  edge_mag,

   output logic [COUNT_WIDTH-1:0] diag_count,
   output logic [COUNT_WIDTH-1:0] vh_count,
   output logic                   stats_valid
);

   localparam int                     c_num_diff    = 4;
   localparam logic [DATA_WIDTH-1:0]  c_default_thr = DATA_WIDTH'(DEFAULT_THRESHOLD);
   localparam logic [COUNT_WIDTH-1:0] c_cnt_max     = '1;
   localparam logic [1:0]             c_ed_none     = 2'b00;
   localparam logic [1:0]             c_ed_vh       = 2'b01;
   localparam logic [1:0]             c_ed_diag     = 2'b10;

   // Difference slots: 0 = main diagonal, 1 = anti-diagonal, 2 = horizontal, 3 = vertical
   logic [DATA_WIDTH-1:0] w_pix_a [c_num_diff];
   logic [DATA_WIDTH-1:0] w_pix_b [c_num_diff];
   logic [DATA_WIDTH-1:0] w_diff  [c_num_diff];

   logic                  w_en;
   logic                  w_xfer;

   logic [DATA_WIDTH-1:0] thr_q;
   logic [DATA_WIDTH-1:0] thr_d;

   logic                  s1_valid_q;
   logic [DATA_WIDTH-1:0] s1_diff_q [c_num_diff];
   logic [DATA_WIDTH-1:0] s1_thr_q;

   logic                  w_is_diag;
   logic                  w_is_vh;
   logic [1:0]            w_class;
   logic [DATA_WIDTH-1:0] w_max_d;
   logic [DATA_WIDTH-1:0] w_max_hv;
   logic [DATA_WIDTH-1:0] w_mag;

   logic                  out_valid_q;
   logic [1:0]            ed_q;
   logic [DATA_WIDTH-1:0] mag_q;

   logic [COUNT_WIDTH-1:0] run_diag_q, run_diag_d;
   logic [COUNT_WIDTH-1:0] run_vh_q,   run_vh_d;
   logic [COUNT_WIDTH-1:0] lat_diag_q, lat_diag_d;
   logic [COUNT_WIDTH-1:0] lat_vh_q,   lat_vh_d;
   logic [COUNT_WIDTH-1:0] w_diag_next;
   logic [COUNT_WIDTH-1:0] w_vh_next;
   logic                   stats_valid_q;

   function automatic logic [COUNT_WIDTH-1:0] sat_inc(
      input logic [COUNT_WIDTH-1:0] cnt,
      input logic                   inc
   );
      if (inc && (cnt != c_cnt_max)) begin
         return cnt + 1'b1;
      end
      return cnt;
   endfunction

   assign w_en        = ~out_valid_q | output_ready;
   assign w_xfer      = out_valid_q & output_ready;
   assign input_ready = w_en;

   assign w_pix_a[0] = input_pixel_1;
   assign w_pix_b[0] = input_pixel_9;
   assign w_pix_a[1] = input_pixel_3;
   assign w_pix_b[1] = input_pixel_7;
   assign w_pix_a[2] = input_pixel_4;
   assign w_pix_b[2] = input_pixel_6;
   assign w_pix_a[3] = input_pixel_2;
   assign w_pix_b[3] = input_pixel_8;

   generate
      for (genvar gi = 0; gi < c_num_diff; gi++) begin : g_absdiff
         assign w_diff[gi] = (w_pix_a[gi] >= w_pix_b[gi]) ? (w_pix_a[gi] - w_pix_b[gi])
                                                          : (w_pix_b[gi] - w_pix_a[gi]);
      end
   endgenerate

   // Threshold loads regardless of stall; stage 1 samples the pre-load value.
   always_comb begin
      thr_d = thr_q;
      if (threshold_load) begin
         thr_d = threshold_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         thr_q <= c_default_thr;
      end else begin
         thr_q <= thr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_thr_q   <= c_default_thr;
         for (int i = 0; i < c_num_diff; i++) begin
            s1_diff_q[i] <= '0;
         end
      end else if (w_en) begin
         s1_valid_q <= input_valid;
         s1_thr_q   <= thr_q;
         for (int i = 0; i < c_num_diff; i++) begin
            s1_diff_q[i] <= w_diff[i];
         end
      end
   end

   always_comb begin
      w_is_diag = (s1_diff_q[0] >= s1_thr_q) | (s1_diff_q[1] >= s1_thr_q);
      w_is_vh   = (s1_diff_q[2] >= s1_thr_q) | (s1_diff_q[3] >= s1_thr_q);
      w_class   = c_ed_none;
      if (w_is_diag) begin
         w_class = c_ed_diag;
      end else if (w_is_vh) begin
         w_class = c_ed_vh;
      end
      w_max_d  = (s1_diff_q[0] >= s1_diff_q[1]) ? s1_diff_q[0] : s1_diff_q[1];
      w_max_hv = (s1_diff_q[2] >= s1_diff_q[3]) ? s1_diff_q[2] : s1_diff_q[3];
      w_mag    = (w_max_d >= w_max_hv) ? w_max_d : w_max_hv;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         ed_q        <= c_ed_none;
         mag_q       <= '0;
      end else if (w_en) begin
         out_valid_q <= s1_valid_q;
         ed_q        <= w_class;
         mag_q       <= w_mag;
      end
   end

   // A transfer coinciding with frame_end is folded into the latched count.
   always_comb begin
      w_diag_next = sat_inc(run_diag_q, w_xfer && (ed_q == c_ed_diag));
      w_vh_next   = sat_inc(run_vh_q,   w_xfer && (ed_q == c_ed_vh));
      run_diag_d  = w_diag_next;
      run_vh_d    = w_vh_next;
      lat_diag_d  = lat_diag_q;
      lat_vh_d    = lat_vh_q;
      if (frame_end) begin
         lat_diag_d = w_diag_next;
         lat_vh_d   = w_vh_next;
         run_diag_d = '0;
         run_vh_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_diag_q    <= '0;
         run_vh_q      <= '0;
         lat_diag_q    <= '0;
         lat_vh_q      <= '0;
         stats_valid_q <= 1'b0;
      end else begin
         run_diag_q    <= run_diag_d;
         run_vh_q      <= run_vh_d;
         lat_diag_q    <= lat_diag_d;
         lat_vh_q      <= lat_vh_d;
         stats_valid_q <= frame_end;
      end
   end

   assign output_valid = out_valid_q;
   assign ED_out       = ed_q;
   assign edge_mag     = mag_q;
   assign diag_count   = lat_diag_q;
   assign vh_count     = lat_vh_q;
   assign stats_valid  = stats_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_edge_detect_pipe.sv
// ============================================================================
// Module      : tb_edge_detect_pipe
// Description : Directed scoreboard bench for edge_detect_pipe (default and
//               COUNT_WIDTH=2 instances driven in parallel).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edge_detect_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       input_valid;
   logic       output_ready;
   logic       th_load;
   logic [7:0] th_in;
   logic       frame_end;
   logic [7:0] p [1:9];

   logic        input_ready,  output_valid,  stats;
   logic [1:0]  ed;
   logic [7:0]  mag;
   logic [19:0] dcnt, vcnt;

   logic        input_ready2, output_valid2, stats2;
   logic [1:0]  ed2;
   logic [7:0]  mag2;
   logic [1:0]  dcnt2, vcnt2;

   int n_checks = 0;
   int n_err    = 0;
   logic [9:0] exp_q [$];
   int thr_m;
   int run_d, run_v, lat_d, lat_v;
   bit exp_stats;
   logic [1:0] save_ed;
   logic [7:0] save_mag;

   always #5 clk = ~clk;

   edge_detect_pipe #(.DATA_WIDTH(8), .DEFAULT_THRESHOLD(80), .COUNT_WIDTH(20)) dut (
      .clk(clk), .rst(rst),
      .input_valid(input_valid), .input_ready(input_ready),
      .input_pixel_1(p[1]), .input_pixel_2(p[2]), .input_pixel_3(p[3]), .input_pixel_4(p[4]),
      .input_pixel_6(p[6]), .input_pixel_7(p[7]), .input_pixel_8(p[8]), .input_pixel_9(p[9]),
      .threshold_load(th_load), .threshold_in(th_in), .frame_end(frame_end),
      .output_valid(output_valid), .output_ready(output_ready),
      .ED_out(ed), .edge_mag(mag),
      .diag_count(dcnt), .vh_count(vcnt), .stats_valid(stats)
   );

   edge_detect_pipe #(.DATA_WIDTH(8), .DEFAULT_THRESHOLD(80), .COUNT_WIDTH(2)) dut2 (
      .clk(clk), .rst(rst),
      .input_valid(input_valid), .input_ready(input_ready2),
      .input_pixel_1(p[1]), .input_pixel_2(p[2]), .input_pixel_3(p[3]), .input_pixel_4(p[4]),
      .input_pixel_6(p[6]), .input_pixel_7(p[7]), .input_pixel_8(p[8]), .input_pixel_9(p[9]),
      .threshold_load(th_load), .threshold_in(th_in), .frame_end(frame_end),
      .output_valid(output_valid2), .output_ready(output_ready),
      .ED_out(ed2), .edge_mag(mag2),
      .diag_count(dcnt2), .vh_count(vcnt2), .stats_valid(stats2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int absd(input logic [7:0] a, input logic [7:0] b);
      int r;
      r = int'(a) - int'(b);
      return (r < 0) ? -r : r;
   endfunction

   function automatic int sat2(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   // Reference: classification and magnitude straight from the pixel values.
   function automatic logic [9:0] model();
      int d [4];
      int mx;
      logic [1:0] c;
      d[0] = absd(p[1], p[9]);
      d[1] = absd(p[3], p[7]);
      d[2] = absd(p[4], p[6]);
      d[3] = absd(p[2], p[8]);
      if (d[0] >= thr_m || d[1] >= thr_m)      c = 2'b10;
      else if (d[2] >= thr_m || d[3] >= thr_m) c = 2'b01;
      else                                     c = 2'b00;
      mx = 0;
      for (int i = 0; i < 4; i++) if (d[i] > mx) mx = d[i];
      return {c, mx[7:0]};
   endfunction

   task automatic win(input int a1, input int a2, input int a3, input int a4,
                      input int a6, input int a7, input int a8, input int a9);
      p[1] = a1[7:0]; p[2] = a2[7:0]; p[3] = a3[7:0]; p[4] = a4[7:0];
      p[5] = 8'd0;    p[6] = a6[7:0]; p[7] = a7[7:0]; p[8] = a8[7:0]; p[9] = a9[7:0];
   endtask

   // One clock: book-keep the handshakes seen before the edge, then check stats after it.
   task automatic tick();
      logic [9:0] e;
      bit xfer, acc;
      int inc_d, inc_v;
      #1;
      xfer  = output_valid && output_ready;
      acc   = input_valid && input_ready;
      inc_d = 0;
      inc_v = 0;
      if (xfer) begin
         n_checks++;
         assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL unexpected_output: observed ED=%0d mag=%0d expected no output", ed, mag);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_ed",  ed,   e[9:8]);
            check("sb_mag", mag,  e[7:0]);
            check("sb_ed2", ed2,  e[9:8]);
            check("sb_mag2", mag2, e[7:0]);
            check("sb_ov2", output_valid2, 1);
            if (e[9:8] == 2'b10) inc_d = 1;
            else if (e[9:8] == 2'b01) inc_v = 1;
         end
      end
      if (acc) exp_q.push_back(model());
      if (th_load) thr_m = int'(th_in);
      if (frame_end) begin
         lat_d = run_d + inc_d;
         lat_v = run_v + inc_v;
         run_d = 0;
         run_v = 0;
         exp_stats = 1'b1;
      end else begin
         run_d += inc_d;
         run_v += inc_v;
         exp_stats = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check("stats_valid",  stats,  exp_stats);
      check("stats_valid2", stats2, exp_stats);
      if (exp_stats) begin
         check("diag_count",  dcnt,  lat_d);
         check("vh_count",    vcnt,  lat_v);
         check("diag_count2", dcnt2, sat2(lat_d));
         check("vh_count2",   vcnt2, sat2(lat_v));
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      input_valid = 1'b0;
      while (exp_q.size() != 0 && k < 20) begin
         tick();
         k++;
      end
      check("drain_empty", exp_q.size(), 0);
      check("drain_ov_low", output_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: observed no completion expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; input_valid = 1'b0; output_ready = 1'b1;
      th_load = 1'b0; th_in = 8'd0; frame_end = 1'b0;
      win(0, 0, 0, 0, 0, 0, 0, 0);
      thr_m = 80; run_d = 0; run_v = 0; lat_d = 0; lat_v = 0; exp_stats = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ov",    output_valid, 0);
      check("rst_ed",    ed,   0);
      check("rst_mag",   mag,  0);
      check("rst_dcnt",  dcnt, 0);
      check("rst_vcnt",  vcnt, 0);
      check("rst_stats", stats, 0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", input_ready, 1);

      // Latency of the default diagonal window
      win(100, 50, 50, 50, 50, 50, 50, 10);
      input_valid = 1'b1;
      tick();
      input_valid = 1'b0;
      check("lat_cycle1_ov", output_valid, 0);
      tick();
      check("lat_cycle2_ov", output_valid, 1);
      check("lat_ed",  ed,  2'b10);
      check("lat_mag", mag, 90);
      drain();

      // Threshold equal vs one below
      input_valid = 1'b1;
      win(50, 50, 50, 200, 120, 50, 50, 50);
      tick();
      win(50, 50, 50, 200, 121, 50, 50, 50);
      tick();
      drain();

      // Threshold load: same-cycle window judged by the old value
      win(0, 60, 0, 0, 0, 0, 40, 0);
      th_in = 8'd20; th_load = 1'b1; input_valid = 1'b1;
      tick();
      th_load = 1'b0;
      tick();
      drain();

      // Stream 4, stall 3 cycles with threshold reload during the stall
      input_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         win(10 * i, 30, 5 * i, 40, 0, 25, 0, 3);
         tick();
      end
      win(200, 0, 0, 0, 0, 0, 0, 0);
      output_ready = 1'b0;
      th_in = 8'd80; th_load = 1'b1;
      #1;
      save_ed = ed;
      save_mag = mag;
      check("stall_ov", output_valid, 1);
      for (int i = 0; i < 3; i++) begin
         check("stall_ready",  input_ready,  0);
         check("stall_ready2", input_ready2, 0);
         check("stall_ov_hold", output_valid, 1);
         check("stall_ed_hold", ed,  save_ed);
         check("stall_mag_hold", mag, save_mag);
         tick();
         th_load = 1'b0;
      end
      output_ready = 1'b1;
      drain();

      // Clean frame boundary, then 5 diag / 3 vh / 2 none with frame_end on the last transfer
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      input_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         case (i)
            0, 3, 4, 7, 9: win(100, 50, 50, 50, 50, 50, 50, 10);
            1, 5, 8:       win(50, 50, 50, 200, 120, 50, 50, 50);
            default:       win(50, 50, 50, 50, 50, 50, 50, 50);
         endcase
         tick();
      end
      input_valid = 1'b0;
      tick();
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      check("frame_diag", dcnt, 5);
      check("frame_vh",   vcnt, 3);
      check("sat_diag2",  dcnt2, 3);
      tick();
      check("frame_diag_hold", dcnt, 5);

      // Empty frame
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      check("empty_diag", dcnt, 0);
      check("empty_vh",   vcnt, 0);

      // Threshold zero: flat window is still diagonal
      th_in = 8'd0; th_load = 1'b1;
      tick();
      th_load = 1'b0;
      input_valid = 1'b1;
      win(50, 50, 50, 50, 50, 50, 50, 50);
      tick();
      win(7, 1, 2, 3, 4, 5, 6, 8);
      tick();
      drain();
      th_in = 8'd80; th_load = 1'b1;
      tick();
      th_load = 1'b0;

      // Reset in the middle of a stalled stream
      input_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         win(100, 50, 50, 50, 50, 50, 50, 10);
         tick();
      end
      output_ready = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check("arst_ov",    output_valid, 0);
      check("arst_ov2",   output_valid2, 0);
      check("arst_stats", stats, 0);
      check("arst_dcnt",  dcnt, 0);
      check("arst_vcnt",  vcnt, 0);
      check("arst_dcnt2", dcnt2, 0);
      check("arst_ready", input_ready, 1);
      exp_q.delete();
      thr_m = 80; run_d = 0; run_v = 0; lat_d = 0; lat_v = 0;
      input_valid = 1'b0;
      output_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) tick();
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      check("post_rst_diag", dcnt, 0);
      check("post_rst_vh",   vcnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/edge_detect_pipe.md
EDGE_DETECT_PIPE -- requirements
Module: edge_detect_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 Parameter DEFAULT_THRESHOLD, default 80: threshold register value after reset; must fit in DATA_WIDTH bits.
REQ-003 Parameter COUNT_WIDTH, default 20: width of the per-frame edge counters.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 input_valid  input  1  a 3x3 window is presented this cycle.
REQ-007 input_ready  output  1  the block accepts the window this cycle.
REQ-008 input_pixel_1..4, input_pixel_6..9  input  DATA_WIDTH each  3x3 neighbours in raster order; the centre pixel is unused.
REQ-009 threshold_load  input  1  load threshold_in into the threshold register.
REQ-010 threshold_in  input  DATA_WIDTH  new threshold value.
REQ-011 frame_end  input  1  single-cycle pulse marking end of frame.
REQ-012 output_valid  output  1  ED_out and edge_mag are valid.
REQ-013 output_ready  input  1  downstream accepts the result.
REQ-014 ED_out  output  2  edge class: 2'b10 diagonal, 2'b01 vertical/horizontal, 2'b00 none.
REQ-015 edge_mag  output  DATA_WIDTH  maximum of the four absolute differences.
REQ-016 diag_count  output  COUNT_WIDTH  latched diagonal count of the last completed frame.
REQ-017 vh_count  output  COUNT_WIDTH  latched vertical/horizontal count of the last completed frame.
REQ-018 stats_valid  output  1  one-cycle pulse: diag_count/vh_count were just updated.

Function
REQ-019 A window is accepted when input_valid and input_ready are both 1; a result is transferred when output_valid and output_ready are both 1.
REQ-020 Pipeline enable = ~output_valid | output_ready. input_ready equals the enable; all pipeline registers hold when the enable is 0.
REQ-021 Stage 1 registers four absolute differences: d1=|p1-p9|, d2=|p3-p7|, h=|p4-p6|, v=|p2-p8|. Each is DATA_WIDTH bits unsigned with no overflow. Stage 1 also registers the current threshold and a valid bit.
REQ-022 Stage 2 registers the outputs. ED_out=2'b10 if d1>=T or d2>=T; else 2'b01 if h>=T or v>=T; else 2'b00. T is the threshold captured with that window in stage 1. edge_mag=max(d1,d2,h,v).
REQ-023 Latency is exactly 2 cycles from acceptance to output_valid when output_ready is held at 1. The block sustains a throughput of one window per cycle.
REQ-024 Backpressure: while output_valid=1 and output_ready=0, ED_out, edge_mag and output_valid hold stable and no window is accepted.
REQ-025 A bubble (input_valid=0 while enabled) propagates as an invalid stage. output_valid deasserts after a transfer if no valid data follows.
REQ-026 The threshold register loads threshold_in on any cycle with threshold_load=1, independent of the stall. A window accepted in the load cycle uses the old value; windows accepted afterwards use the new value.
REQ-027 Running counters increment on each transfer classified 2'b10 (diagonal) or 2'b01 (vertical/horizontal). Both counters saturate at all-ones and never wrap.
REQ-028 On frame_end, diag_count/vh_count load the running counts, including any transfer in the same cycle. The running counters then clear to 0, and stats_valid pulses 1 in the following cycle. The latched values hold until the next frame_end.
REQ-029 A frame_end pulse with zero transfers in the frame latches 0/0 and still pulses stats_valid.
REQ-030 A threshold of 0 classifies every window as diagonal. A threshold equal to a difference counts as an edge (>=).

Reset
REQ-031 rst=1 clears, asynchronously: the pipeline valid bits, output_valid, ED_out, edge_mag, the running counters, diag_count, vh_count and stats_valid.
REQ-032 rst=1 sets the threshold register to DEFAULT_THRESHOLD.
REQ-033 After rst deasserts, input_ready=1 on the first cycle.
REQ-034 Reset asserted mid-frame or mid-stall discards all in-flight windows and partial counts, with no output transfer.

Verification
REQ-035 Defaults: p1=100, p9=10, all others 50, output_ready=1 -> ED_out=2'b10 and edge_mag=90 exactly 2 cycles after acceptance.
REQ-036 p4=200, p6=120 (diff 80), others 50 -> ED_out=2'b01, edge_mag=80. Same window with p6=121 -> ED_out=2'b00, edge_mag=79.
REQ-037 Load threshold 20, then p2=60, p8=40, others 0 -> ED_out=2'b01. A window accepted in the load cycle is still judged against 80.
REQ-038 Stream 4 windows, then hold output_ready=0 for 3 cycles -> input_ready=0 and outputs stable throughout. After release, all 4 results emerge in order, none lost or duplicated.
REQ-039 Frame of 5 diagonal, 3 vertical/horizontal and 2 no-edge transfers, then frame_end -> next cycle stats_valid=1, diag_count=5, vh_count=3. A second empty frame -> diag_count=0, vh_count=0.
REQ-040 COUNT_WIDTH=2, 5 diagonal transfers, frame_end -> diag_count=3 (saturated). Assert rst mid-stream -> output_valid=0 immediately and all counts 0.
